// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and constants
//
// Contents:
//   tx_fifo_state_e  launch sequencer states (IDLE, LAUNCH, WAIT)
//   UART_DATA_WIDTH  default UART payload width in bits

package uart_pkg;

    localparam int UART_DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2
    } tx_fifo_state_e;

endpackage

// File: rtl/uart_sync_fifo.sv
// rtl/uart_sync_fifo.sv - single-clock byte FIFO with occupancy count and flush
//
// Ports:
//   clk      in   clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   wr_en    in   write request; it is accepted only when not full and not flushing
//   wr_data  in   DATA_WIDTH  word to store
//   rd_en    in   read request; it is accepted only when not empty
//   flush    in   synchronous clear of all stored words
//   rd_data  out  DATA_WIDTH  word at the read pointer (combinational)
//   count    out  $clog2(DEPTH+1)  stored words (registered)
//   empty    out  count == 0 (registered)
//   full     out  count == DEPTH (registered)

module uart_sync_fifo #(
    parameter int DEPTH      = 16,
    parameter int DATA_WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         wr_en,
    input  logic [DATA_WIDTH-1:0]        wr_data,
    input  logic                         rd_en,
    input  logic                         flush,
    output logic [DATA_WIDTH-1:0]        rd_data,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty,
    output logic                         full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t FULL_CNT = cnt_t'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    ptr_t wr_ptr;
    ptr_t rd_ptr;
    cnt_t count_next;
    logic push;
    logic pop;

    // A push in a flush cycle is dropped so the FIFO really is empty afterwards.
    assign push    = wr_en && !full && !flush;
    assign pop     = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    always_comb begin
        count_next = count;
        if (flush) begin
            count_next = '0;
        end else begin
            case ({push, pop})
                2'b10:   count_next = count + cnt_t'(1);
                2'b01:   count_next = count - cnt_t'(1);
                default: count_next = count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + ptr_t'(1);
            end
            // Flush aligns the read pointer to the write pointer; a pop in the
            // same cycle has already copied its word out, so it is not lost.
            if (flush) begin
                rd_ptr <= wr_ptr;
            end else if (pop) begin
                rd_ptr <= rd_ptr + ptr_t'(1);
            end
            count <= count_next;
            empty <= (count_next == '0);
            full  <= (count_next == FULL_CNT);
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - byte queue and launch sequencer in front of the UART transmitter
//
// Ports:
//   tx_clk      in   transmitter clock, rising edge
//   tx_rstn     in   asynchronous active-low reset
//   wr_valid    in   producer has a byte on wr_data
//   wr_data     in   DATA_WIDTH  byte to queue
//   wr_ready    out  queue can accept (!full)
//   flush       in   drop queued bytes; the in-flight byte is unaffected
//   uart_start  out  one-cycle launch pulse to the transmitter
//   uart_din    out  DATA_WIDTH  byte being sent, held from pop to next pop
//   uart_done   in   one-cycle end-of-packet pulse from the transmitter
//   count       out  queued bytes, excluding the in-flight byte
//   empty       out  count == 0
//   full        out  count == DEPTH
//   busy        out  sequencer not idle

module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int DATA_WIDTH = UART_DATA_WIDTH
) (
    input  logic                         tx_clk,
    input  logic                         tx_rstn,
    input  logic                         wr_valid,
    input  logic [DATA_WIDTH-1:0]        wr_data,
    output logic                         wr_ready,
    input  logic                         flush,
    output logic                         uart_start,
    output logic [DATA_WIDTH-1:0]        uart_din,
    input  logic                         uart_done,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty,
    output logic                         full,
    output logic                         busy
);

    tx_fifo_state_e        state;
    tx_fifo_state_e        state_next;
    logic                  pop;
    logic [DATA_WIDTH-1:0] head_data;

    uart_sync_fifo #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_fifo (
        .clk     (tx_clk),
        .rst_n   (tx_rstn),
        .wr_en   (wr_valid),
        .wr_data (wr_data),
        .rd_en   (pop),
        .flush   (flush),
        .rd_data (head_data),
        .count   (count),
        .empty   (empty),
        .full    (full)
    );

    // Registered full only: a pop in the same cycle does not open the door.
    assign wr_ready = !full;
    assign busy     = (state != IDLE);

    always_ff @(posedge tx_clk or negedge tx_rstn) begin
        if (!tx_rstn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // uart_start decodes straight from state so an asynchronous reset drops it at once.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        uart_start = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    state_next = LAUNCH;
                end
            end
            LAUNCH: begin
                uart_start = 1'b1;
                state_next = WAIT;
            end
            WAIT: begin
                if (uart_done) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge tx_clk or negedge tx_rstn) begin
        if (!tx_rstn) begin
            uart_din <= '0;
        end else if (pop) begin
            uart_din <= head_data;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - directed self-checking bench for uart_tx_fifo

module tb_uart_tx_fifo;

    logic       tx_clk;
    logic       tx_rstn;
    logic       wr_valid;
    logic [7:0] wr_data;
    logic       wr_ready;
    logic       flush;
    logic       uart_start;
    logic [7:0] uart_din;
    logic       uart_done;
    logic [4:0] count;
    logic       empty;
    logic       full;
    logic       busy;

    int n_checks;
    int n_errors;

    logic [7:0] start_log [$];

    uart_tx_fifo #(
        .DEPTH      (16),
        .DATA_WIDTH (8)
    ) dut (
        .tx_clk     (tx_clk),
        .tx_rstn    (tx_rstn),
        .wr_valid   (wr_valid),
        .wr_data    (wr_data),
        .wr_ready   (wr_ready),
        .flush      (flush),
        .uart_start (uart_start),
        .uart_din   (uart_din),
        .uart_done  (uart_done),
        .count      (count),
        .empty      (empty),
        .full       (full),
        .busy       (busy)
    );

    initial tx_clk = 1'b0;
    always #5 tx_clk = ~tx_clk;

    always @(negedge tx_clk) begin
        if (uart_start === 1'b1) begin
            start_log.push_back(uart_din);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge tx_clk);
    endtask

    task automatic done_pulse();
        uart_done = 1'b1;
        step();
        uart_done = 1'b0;
    endtask

    // Push one byte from IDLE/empty and run it to WAIT (three edges).
    task automatic launch_one(input logic [7:0] d);
        wr_valid = 1'b1;
        wr_data  = d;
        step();
        wr_valid = 1'b0;
        step();
        step();
    endtask

    task automatic push_n(input logic [7:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            wr_valid = 1'b1;
            wr_data  = base + 8'(i);
            step();
        end
        wr_valid = 1'b0;
    endtask

    initial begin
        int bad;
        logic [7:0] burst [4];
        n_checks  = 0;
        n_errors  = 0;
        tx_rstn   = 1'b0;
        wr_valid  = 1'b0;
        wr_data   = 8'h00;
        flush     = 1'b0;
        uart_done = 1'b0;

        // ---------------- reset values
        step();
        step();
        check("rst_wr_ready", wr_ready, 1);
        check("rst_start", uart_start, 0);
        check("rst_din", uart_din, 8'h00);
        check("rst_count", count, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_busy", busy, 0);
        tx_rstn = 1'b1;
        step();

        // ---------------- single byte, done ignored in LAUNCH
        wr_valid = 1'b1;
        wr_data  = 8'hA2;
        step();                                  // after edge N
        wr_valid = 1'b0;
        check("single_empty_n", empty, 0);
        check("single_count_n", count, 1);
        check("single_start_n", uart_start, 0);
        step();                                  // after N+1
        check("single_start_n1", uart_start, 1);
        check("single_din_n1", uart_din, 8'hA2);
        check("single_count_n1", count, 0);
        uart_done = 1'b1;                        // sampled in LAUNCH: must be ignored
        step();                                  // after N+2
        uart_done = 1'b0;
        check("single_start_n2", uart_start, 0);
        check("single_done_ignored", busy, 1);
        bad = 0;
        for (int i = 0; i < 620; i++) begin
            step();
            if (uart_start !== 1'b0 || uart_din !== 8'hA2 || busy !== 1'b1) bad++;
        end
        check("single_hold", bad, 0);
        done_pulse();
        check("single_busy_after", busy, 0);
        step();
        check("single_no_restart", uart_start, 0);

        // ---------------- burst of four
        burst[0] = 8'hA5; burst[1] = 8'hA8; burst[2] = 8'hAB; burst[3] = 8'hAE;
        start_log.delete();
        for (int i = 0; i < 4; i++) begin
            wr_valid = 1'b1;
            wr_data  = burst[i];
            step();
        end
        wr_valid = 1'b0;
        check("burst_count3", count, 3);
        check("burst_din0", uart_din, 8'hA5);
        check("burst_busy", busy, 1);
        for (int k = 1; k < 4; k++) begin
            done_pulse();                        // after M
            check("burst_idle_m", busy, 0);
            check("burst_nostart_m", uart_start, 0);
            step();                              // after M+1
            check("burst_start", uart_start, 1);
            check("burst_din", uart_din, burst[k]);
            check("burst_count", count, 32'(3 - k));
            step();
        end
        done_pulse();
        step();
        check("burst_log_size", start_log.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < start_log.size()) check("burst_log", start_log[i], burst[i]);
        end

        // ---------------- full, held 17th, wrap
        launch_one(8'h40);
        push_n(8'h50, 16);
        check("full_count", count, 16);
        check("full_flag", full, 1);
        check("full_ready", wr_ready, 0);
        wr_valid = 1'b1;
        wr_data  = 8'h60;
        step();
        step();
        check("full_held_count", count, 16);
        uart_done = 1'b1;
        step();                                  // after M: IDLE, still full
        uart_done = 1'b0;
        check("full_m_count", count, 16);
        step();                                  // after M+1: pop, push blocked
        check("full_pop_count", count, 15);
        check("full_pop_ready", wr_ready, 1);
        check("full_pop_din", uart_din, 8'h50);
        step();                                  // after M+2: held byte accepted
        wr_valid = 1'b0;
        check("full_refill_count", count, 16);
        check("full_refill_flag", full, 1);
        bad = 0;
        for (int k = 1; k <= 16; k++) begin
            done_pulse();
            step();
            if (uart_start !== 1'b1 || uart_din !== 8'h50 + 8'(k)) bad++;
            step();
        end
        check("full_drain_order", bad, 0);
        done_pulse();
        check("full_end_empty", empty, 1);
        check("full_end_busy", busy, 0);

        // ---------------- simultaneous push and pop at count 3
        launch_one(8'h71);
        push_n(8'h72, 3);
        check("simul_pre_count", count, 3);
        done_pulse();                            // now IDLE with count 3
        wr_valid = 1'b1;
        wr_data  = 8'h75;
        step();
        wr_valid = 1'b0;
        check("simul_count", count, 3);
        check("simul_start", uart_start, 1);
        check("simul_din", uart_din, 8'h72);
        step();
        bad = 0;
        for (int k = 3; k <= 5; k++) begin
            done_pulse();
            step();
            if (uart_start !== 1'b1 || uart_din !== 8'h70 + 8'(k)) bad++;
            step();
        end
        check("simul_order", bad, 0);
        done_pulse();
        check("simul_empty", empty, 1);

        // ---------------- flush with five queued and one in flight
        launch_one(8'h81);
        push_n(8'h82, 5);
        check("flush_pre_count", count, 5);
        flush    = 1'b1;
        wr_valid = 1'b1;
        wr_data  = 8'h99;
        step();
        flush    = 1'b0;
        wr_valid = 1'b0;
        start_log.delete();
        check("flush_count", count, 0);
        check("flush_empty", empty, 1);
        check("flush_busy", busy, 1);
        check("flush_din", uart_din, 8'h81);
        done_pulse();
        check("flush_done_idle", busy, 0);
        for (int i = 0; i < 5; i++) step();
        check("flush_no_start", start_log.size(), 0);
        launch_one(8'h87);
        check("flush_after_din", uart_din, 8'h87);
        done_pulse();
        step();

        // ---------------- asynchronous reset in WAIT
        launch_one(8'h91);
        push_n(8'h92, 2);
        check("rstw_pre_busy", busy, 1);
        #2;
        tx_rstn = 1'b0;
        #1;
        check("rstw_busy", busy, 0);
        check("rstw_count", count, 0);
        check("rstw_empty", empty, 1);
        check("rstw_din", uart_din, 8'h00);
        check("rstw_start", uart_start, 0);
        check("rstw_ready", wr_ready, 1);
        step();
        tx_rstn = 1'b1;
        step();
        wr_valid = 1'b1;
        wr_data  = 8'h3C;
        step();
        wr_valid = 1'b0;
        step();
        check("rstw_new_start", uart_start, 1);
        check("rstw_new_din", uart_din, 8'h3C);
        check("rstw_new_count", count, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
